// File: rtl/uc_bcast_scheduler_pkg.sv
// Shared types for the unit-clause broadcast path: literal type, engine count, scheduler state.
package uc_bcast_scheduler_pkg;

    localparam int LIT_W       = 16;
    localparam int NUM_ENGINE  = 2;
    localparam int LIT_IDX_MAX = (1 << (LIT_W - 1)) - 1;

    typedef logic [LIT_W-1:0] lit_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } ucb_state_t;

endpackage

// File: rtl/uc_bcast_scheduler_if.sv
// Arbiter-side literal handshake plus the engine-side broadcast bus of the UC scheduler.
interface uc_bcast_scheduler_if;
    import uc_bcast_scheduler_pkg::*;

    lit_t                  uca2ucb_lit;
    logic                  uca2ucb_valid;
    logic                  ucb2uca_ready;
    logic [NUM_ENGINE-1:0] eng_full;
    lit_t                  ucb2eng_lit;
    logic [NUM_ENGINE-1:0] ucb2eng_push;

    modport master (
        output uca2ucb_lit, uca2ucb_valid, eng_full,
        input  ucb2uca_ready, ucb2eng_lit, ucb2eng_push
    );

    modport slave (
        input  uca2ucb_lit, uca2ucb_valid, eng_full,
        output ucb2uca_ready, ucb2eng_lit, ucb2eng_push
    );
endinterface

// File: rtl/uc_bcast_scheduler_fifo.sv
// ucb_fifo: single-read/single-write synchronous FIFO; head is combinational from the read pointer.
// Latency: written data is visible at head the cycle after the write; clr and rst empty it.
module ucb_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  T                       push_dat,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/uc_bcast_scheduler.sv
// Broadcasts buffered unit-clause literals to every engine, retiring each once all engines took it.
// Latency 2 cycles from accept to push; a full engine stalls only its own copy. Optional UCB_DEDUP_EN.
module uc_bcast_scheduler
    import uc_bcast_scheduler_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int STALL_LIMIT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    uc_bcast_scheduler_if.slave    bus,
    input  logic                   flush,
    output logic                   ucb_idle,
    output logic                   ucb_stall_err,
    output logic [15:0]            drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;

    ucb_state_t            state_q, state_d;
    logic [NUM_ENGINE-1:0] pending_q, pending_d, push, pend_left;
    lit_t                  hold_q, hold_d, fifo_head;
    logic                  fifo_full, fifo_empty, pop, accept, dup, bcast;
    logic [CW-1:0]         fifo_count;
    logic [7:0]            stall_cnt;

    assign accept            = bus.uca2ucb_valid && bus.ucb2uca_ready;
    assign bus.ucb2uca_ready = rst && !fifo_full && !flush;
    assign bcast             = rst && (state_q == BCAST);
    assign push              = bcast ? (pending_q & ~bus.eng_full) : '0;
    assign pend_left         = pending_q & ~push;
    assign bus.ucb2eng_push  = push;
    assign bus.ucb2eng_lit   = bcast ? hold_q : '0;
    assign ucb_idle          = !rst || ((fifo_count == '0) && (state_q == IDLE));
    assign ucb_stall_err     = rst && (int'(stall_cnt) >= STALL_LIMIT);

    ucb_fifo #(.DEPTH(DEPTH), .T(lit_t)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (accept && !dup),
        .push_dat (bus.uca2ucb_lit),
        .pop      (pop && !flush),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state_q   <= IDLE;
            pending_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
        end
    end

    // Pops only from the registered FIFO state, so a same-cycle write waits one cycle.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    hold_d    = fifo_head;
                    pending_d = '1;
                    state_d   = BCAST;
                end
            end
            BCAST: begin
                pending_d = pend_left;
                if (pend_left == '0) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        hold_d    = fifo_head;
                        pending_d = '1;
                    end else begin
                        hold_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst || flush || (state_q != BCAST) || (push != '0)) begin
            stall_cnt <= '0;
        end else if (stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

`ifdef UCB_DEDUP_EN
    lit_t last_lit;
    logic last_vld;

    assign dup = last_vld && (bus.uca2ucb_lit == last_lit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_lit <= '0;
            last_vld <= 1'b0;
            drop_cnt <= '0;
        end else if (flush) begin
            last_vld <= 1'b0;
        end else if (accept) begin
            last_lit <= bus.uca2ucb_lit;
            last_vld <= 1'b1;
            if (dup && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    assign dup      = 1'b0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uc_bcast_scheduler.sv
// Directed bench for uc_bcast_scheduler; expected values are hand-derived cycle by cycle.
module tb_uc_bcast_scheduler;
    import uc_bcast_scheduler_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        ucb_idle, ucb_stall_err;
    logic [15:0] drop_cnt;
    int          errors = 0;
    int          checks = 0;

    uc_bcast_scheduler_if bus ();

    uc_bcast_scheduler #(.DEPTH(DEPTH), .STALL_LIMIT(255)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .flush         (flush),
        .ucb_idle      (ucb_idle),
        .ucb_stall_err (ucb_stall_err),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Move to 1 ns after the next rising edge; inputs are driven here, checks follow after a further #1.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.uca2ucb_valid = 1'b1;
        bus.uca2ucb_lit   = 16'd3;
        bus.eng_full      = 2'b00;
        rst               = 1'b0;
        repeat (3) nxt();
        #1;
        checks += 6;
        if (bus.ucb2uca_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", bus.ucb2uca_ready); end
        if (bus.ucb2eng_push !== 2'b00) begin errors++; $display("FAIL reset_push: got %0b want 00", bus.ucb2eng_push); end
        if (bus.ucb2eng_lit !== 16'd0) begin errors++; $display("FAIL reset_lit: got %0d want 0", bus.ucb2eng_lit); end
        if (ucb_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b want 1", ucb_idle); end
        if (ucb_stall_err !== 1'b0) begin errors++; $display("FAIL reset_stall_err: got %0b want 0", ucb_stall_err); end
        if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        bus.uca2ucb_valid = 1'b0;
        nxt();
        rst = 1'b1;
    endtask

    task automatic test_single();
        nxt();
        bus.uca2ucb_valid = 1'b1;
        bus.uca2ucb_lit   = 16'd5;
        #1;
        checks++;
        if (bus.ucb2uca_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", bus.ucb2uca_ready); end
        nxt();
        bus.uca2ucb_valid = 1'b0;
        #1;
        checks += 2;
        if (bus.ucb2eng_push !== 2'b00) begin errors++; $display("FAIL single_c1_push: got %0b want 00", bus.ucb2eng_push); end
        if (ucb_idle !== 1'b0) begin errors++; $display("FAIL single_c1_idle: got %0b want 0", ucb_idle); end
        nxt();
        #1;
        checks += 2;
        if (bus.ucb2eng_push !== 2'b11) begin errors++; $display("FAIL single_c2_push: got %0b want 11", bus.ucb2eng_push); end
        if (bus.ucb2eng_lit !== 16'd5) begin errors++; $display("FAIL single_c2_lit: got %0d want 5", bus.ucb2eng_lit); end
        nxt();
        #1;
        checks += 3;
        if (bus.ucb2eng_push !== 2'b00) begin errors++; $display("FAIL single_c3_push: got %0b want 00", bus.ucb2eng_push); end
        if (bus.ucb2eng_lit !== 16'd0) begin errors++; $display("FAIL single_c3_lit: got %0d want 0", bus.ucb2eng_lit); end
        if (ucb_idle !== 1'b1) begin errors++; $display("FAIL single_c3_idle: got %0b want 1", ucb_idle); end
    endtask

    task automatic test_partial();
        nxt();
        bus.uca2ucb_valid = 1'b1;
        bus.uca2ucb_lit   = 16'd7;
        nxt();
        bus.uca2ucb_lit   = 16'd8;
        nxt();
        bus.uca2ucb_valid = 1'b0;
        bus.eng_full      = 2'b10;
        #1;
        checks += 2;
        if (bus.ucb2eng_push !== 2'b01) begin errors++; $display("FAIL partial_first_push: got %0b want 01", bus.ucb2eng_push); end
        if (bus.ucb2eng_lit !== 16'd7) begin errors++; $display("FAIL partial_first_lit: got %0d want 7", bus.ucb2eng_lit); end
        for (int i = 0; i < 3; i++) begin
            nxt();
            #1;
            checks += 2;
            if (bus.ucb2eng_push !== 2'b00) begin errors++; $display("FAIL partial_blocked_push[%0d]: got %0b want 00", i, bus.ucb2eng_push); end
            if (bus.ucb2eng_lit !== 16'd7) begin errors++; $display("FAIL partial_blocked_lit[%0d]: got %0d want 7", i, bus.ucb2eng_lit); end
        end
        nxt();
        bus.eng_full = 2'b00;
        #1;
        checks += 2;
        if (bus.ucb2eng_push !== 2'b10) begin errors++; $display("FAIL partial_late_push: got %0b want 10", bus.ucb2eng_push); end
        if (bus.ucb2eng_lit !== 16'd7) begin errors++; $display("FAIL partial_late_lit: got %0d want 7", bus.ucb2eng_lit); end
        nxt();
        #1;
        checks += 2;
        if (bus.ucb2eng_push !== 2'b11) begin errors++; $display("FAIL partial_next_push: got %0b want 11", bus.ucb2eng_push); end
        if (bus.ucb2eng_lit !== 16'd8) begin errors++; $display("FAIL partial_next_lit: got %0d want 8", bus.ucb2eng_lit); end
        nxt();
        #1;
        checks++;
        if (ucb_idle !== 1'b1) begin errors++; $display("FAIL partial_idle: got %0b want 1", ucb_idle); end
    endtask

    // DEPTH entries in the FIFO plus one held literal are accepted before ready drops.
    task automatic test_full_fifo_back_to_back();
        int acc = 0;
        int idx = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        nxt();
        bus.eng_full = 2'b11;
        for (int c = 0; c < DEPTH + 4; c++) begin
            bus.uca2ucb_valid = 1'b1;
            bus.uca2ucb_lit   = 16'(20 + acc);
            #1;
            if (bus.ucb2uca_ready) acc++;
            nxt();
        end
        bus.uca2ucb_valid = 1'b0;
        #1;
        checks += 2;
        if (acc !== DEPTH + 1) begin errors++; $display("FAIL full_accepts: got %0d want %0d", acc, DEPTH + 1); end
        if (bus.ucb2uca_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", bus.ucb2uca_ready); end
        nxt();
        bus.eng_full = 2'b00;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.ucb2eng_push != 2'b00) begin
                checks += 2;
                if (bus.ucb2eng_push !== 2'b11) begin errors++; $display("FAIL full_push[%0d]: got %0b want 11", idx, bus.ucb2eng_push); end
                if (bus.ucb2eng_lit !== 16'(20 + idx)) begin errors++; $display("FAIL full_order[%0d]: got %0d want %0d", idx, bus.ucb2eng_lit, 20 + idx); end
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                idx++;
            end
            nxt();
        end
        checks += 3;
        if (idx !== DEPTH + 1) begin errors++; $display("FAIL full_delivered: got %0d want %0d", idx, DEPTH + 1); end
        if (last_cyc - first_cyc !== DEPTH) begin errors++; $display("FAIL back_to_back_span: got %0d want %0d", last_cyc - first_cyc, DEPTH); end
        #1;
        if (ucb_idle !== 1'b1) begin errors++; $display("FAIL full_idle: got %0b want 1", ucb_idle); end
    endtask

    task automatic test_flush();
        int seen = 0;
        nxt();
        bus.eng_full = 2'b11;
        for (int i = 0; i < 4; i++) begin
            bus.uca2ucb_valid = 1'b1;
            bus.uca2ucb_lit   = 16'(30 + i);
            nxt();
        end
        bus.uca2ucb_valid = 1'b0;
        nxt();
        flush             = 1'b1;
        bus.uca2ucb_valid = 1'b1;
        bus.uca2ucb_lit   = 16'd99;
        #1;
        checks += 2;
        if (bus.ucb2uca_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", bus.ucb2uca_ready); end
        if (bus.ucb2eng_lit !== 16'd30) begin errors++; $display("FAIL flush_cycle_lit: got %0d want 30", bus.ucb2eng_lit); end
        nxt();
        flush             = 1'b0;
        bus.uca2ucb_valid = 1'b0;
        #1;
        checks += 3;
        if (ucb_idle !== 1'b1) begin errors++; $display("FAIL flush_idle: got %0b want 1", ucb_idle); end
        if (bus.ucb2eng_lit !== 16'd0) begin errors++; $display("FAIL flush_lit: got %0d want 0", bus.ucb2eng_lit); end
        if (bus.ucb2uca_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %0b want 1", bus.ucb2uca_ready); end
        bus.eng_full = 2'b00;
        for (int c = 0; c < 6; c++) begin
            nxt();
            #1;
            if (bus.ucb2eng_push != 2'b00) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_residue: got %0d pushes want 0", seen); end
    endtask

    task automatic test_stall();
        nxt();
        bus.eng_full      = 2'b11;
        bus.uca2ucb_valid = 1'b1;
        bus.uca2ucb_lit   = 16'd40;
        nxt();
        bus.uca2ucb_valid = 1'b0;
        repeat (255) nxt();
        #1;
        checks++;
        if (ucb_stall_err !== 1'b0) begin errors++; $display("FAIL stall_254: got %0b want 0", ucb_stall_err); end
        nxt();
        #1;
        checks++;
        if (ucb_stall_err !== 1'b1) begin errors++; $display("FAIL stall_255: got %0b want 1", ucb_stall_err); end
        nxt();
        bus.eng_full = 2'b00;
        #1;
        checks += 2;
        if (bus.ucb2eng_push !== 2'b11) begin errors++; $display("FAIL stall_release_push: got %0b want 11", bus.ucb2eng_push); end
        if (bus.ucb2eng_lit !== 16'd40) begin errors++; $display("FAIL stall_release_lit: got %0d want 40", bus.ucb2eng_lit); end
        nxt();
        #1;
        checks++;
        if (ucb_stall_err !== 1'b0) begin errors++; $display("FAIL stall_clear: got %0b want 0", ucb_stall_err); end
    endtask

    task automatic test_dedup();
        lit_t got[$];
        lit_t stim[3];
`ifdef UCB_DEDUP_EN
        lit_t exp_l[$] = '{16'd9, 16'd4};
        logic [15:0] exp_drop = 16'd1;
`else
        lit_t exp_l[$] = '{16'd9, 16'd9, 16'd4};
        logic [15:0] exp_drop = 16'd0;
`endif
        stim[0] = 16'd9;
        stim[1] = 16'd9;
        stim[2] = 16'd4;
        nxt();
        for (int i = 0; i < 3; i++) begin
            bus.uca2ucb_valid = 1'b1;
            bus.uca2ucb_lit   = stim[i];
            #1;
            checks++;
            if (bus.ucb2uca_ready !== 1'b1) begin errors++; $display("FAIL dedup_ready[%0d]: got %0b want 1", i, bus.ucb2uca_ready); end
            if (bus.ucb2eng_push == 2'b11) got.push_back(bus.ucb2eng_lit);
            nxt();
        end
        bus.uca2ucb_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.ucb2eng_push == 2'b11) got.push_back(bus.ucb2eng_lit);
            nxt();
        end
        checks += 2;
        if (got.size() !== exp_l.size()) begin errors++; $display("FAIL dedup_count: got %0d want %0d", got.size(), exp_l.size()); end
        if (drop_cnt !== exp_drop) begin errors++; $display("FAIL dedup_drop_cnt: got %0d want %0d", drop_cnt, exp_drop); end
        for (int i = 0; i < exp_l.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_l[i]) begin errors++; $display("FAIL dedup_lit[%0d]: got %0d want %0d", i, got[i], exp_l[i]); end
        end
    endtask

    initial begin
        bus.uca2ucb_valid = 1'b0;
        bus.uca2ucb_lit   = '0;
        bus.eng_full      = '0;
        test_reset();
        test_single();
        test_partial();
        test_full_fifo_back_to_back();
        test_flush();
        test_stall();
        test_dedup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
